// File: rtl/skin_pkg.sv
// Shared types and defaults for the skin segmentation block: FSM encoding,
// coordinate/count widths, default chroma/luma windows and a range helper.
package skin_pkg;

    localparam int CW = 10;
    localparam int NW = 20;

    localparam int IMG_W_DEF = 640;
    localparam int IMG_H_DEF = 480;

    localparam logic [7:0] CB_MIN_DEF = 8'd77;
    localparam logic [7:0] CB_MAX_DEF = 8'd127;
    localparam logic [7:0] CR_MIN_DEF = 8'd133;
    localparam logic [7:0] CR_MAX_DEF = 8'd173;
    localparam logic [7:0] Y_MIN_DEF  = 8'd40;
    localparam logic [7:0] Y_MAX_DEF  = 8'd235;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    function automatic logic in_range(input logic [7:0] v,
                                      input logic [7:0] lo,
                                      input logic [7:0] hi);
        return (v >= lo) && (v <= hi);
    endfunction

endpackage

// File: rtl/skin_threshold.sv
// Combinational skin classifier: inclusive Cb/Cr windows, plus an inclusive
// luma window when SKIN_LUMA_GATE_EN is defined.
module skin_threshold
    import skin_pkg::*;
#(
    parameter logic [7:0] CB_MIN = CB_MIN_DEF,
    parameter logic [7:0] CB_MAX = CB_MAX_DEF,
    parameter logic [7:0] CR_MIN = CR_MIN_DEF,
    parameter logic [7:0] CR_MAX = CR_MAX_DEF,
    parameter logic [7:0] Y_MIN  = Y_MIN_DEF,
    parameter logic [7:0] Y_MAX  = Y_MAX_DEF
) (
    input  logic [7:0] luma_i,
    input  logic [7:0] cb_i,
    input  logic [7:0] cr_i,
    output logic       skin_o
);

    logic chroma_ok;

    assign chroma_ok = in_range(cb_i, CB_MIN, CB_MAX) && in_range(cr_i, CR_MIN, CR_MAX);

`ifdef SKIN_LUMA_GATE_EN
    // Very dark or saturated pixels carry unreliable chroma, so gate them out.
    assign skin_o = chroma_ok && in_range(luma_i, Y_MIN, Y_MAX);
`else
    logic unused_luma;
    assign unused_luma = ^{luma_i, Y_MIN, Y_MAX};
    assign skin_o      = chroma_ok;
`endif

endmodule

// File: rtl/skin_segmenter.sv
// Skin mask generator with per-frame skin count and bounding box statistics.
// Define SKIN_LUMA_GATE_EN to additionally require luma inside [Y_MIN, Y_MAX].
module skin_segmenter
    import skin_pkg::*;
#(
    parameter int         IMG_W  = IMG_W_DEF,
    parameter int         IMG_H  = IMG_H_DEF,
    parameter logic [7:0] CB_MIN = CB_MIN_DEF,
    parameter logic [7:0] CB_MAX = CB_MAX_DEF,
    parameter logic [7:0] CR_MIN = CR_MIN_DEF,
    parameter logic [7:0] CR_MAX = CR_MAX_DEF,
    parameter logic [7:0] Y_MIN  = Y_MIN_DEF,
    parameter logic [7:0] Y_MAX  = Y_MAX_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          pix_valid,
    input  logic          sof,
    input  logic [7:0]    luma_ch,
    input  logic [7:0]    cb_ch,
    input  logic [7:0]    cr_ch,
    output logic          mask_valid,
    output logic          mask_bit,
    output logic          frame_done,
    output logic [NW-1:0] skin_count,
    output logic          bbox_valid,
    output logic [CW-1:0] bbox_xmin,
    output logic [CW-1:0] bbox_xmax,
    output logic [CW-1:0] bbox_ymin,
    output logic [CW-1:0] bbox_ymax
);

    localparam logic [CW-1:0] X_LAST = CW'(IMG_W - 1);
    localparam logic [CW-1:0] Y_LAST = CW'(IMG_H - 1);

    state_e        state_q, state_d;
    logic          acc_pix, last_pix, skin_raw;
    logic [CW-1:0] x_cnt_q, y_cnt_q, cur_x, cur_y;

    logic          s1_valid_q, s1_skin_q, s1_acc_q, s1_sof_q, s1_last_q;
    logic [CW-1:0] s1_x_q, s1_y_q;
    logic          mask_valid_q, mask_bit_q, s2_last_q;

    logic [NW-1:0] acc_count_q, acc_count_d;
    logic          acc_any_q, acc_any_d;
    logic [CW-1:0] acc_xmin_q, acc_xmin_d, acc_xmax_q, acc_xmax_d;
    logic [CW-1:0] acc_ymin_q, acc_ymin_d, acc_ymax_q, acc_ymax_d;

    logic          frame_done_q, bbox_valid_q;
    logic [NW-1:0] skin_count_q;
    logic [CW-1:0] bbox_xmin_q, bbox_xmax_q, bbox_ymin_q, bbox_ymax_q;

    skin_threshold #(
        .CB_MIN(CB_MIN), .CB_MAX(CB_MAX),
        .CR_MIN(CR_MIN), .CR_MAX(CR_MAX),
        .Y_MIN (Y_MIN),  .Y_MAX (Y_MAX)
    ) u_threshold (
        .luma_i(luma_ch),
        .cb_i  (cb_ch),
        .cr_i  (cr_ch),
        .skin_o(skin_raw)
    );

    // Coordinates of the pixel on the input this cycle; sof forces the origin.
    assign cur_x    = sof ? '0 : x_cnt_q;
    assign cur_y    = sof ? '0 : y_cnt_q;
    assign last_pix = acc_pix && (cur_x == X_LAST) && (cur_y == Y_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            x_cnt_q <= '0;
            y_cnt_q <= '0;
        end else if (pix_valid) begin
            if (cur_x == X_LAST) begin
                x_cnt_q <= '0;
                y_cnt_q <= cur_y + 1'b1;
            end else begin
                x_cnt_q <= cur_x + 1'b1;
                y_cnt_q <= cur_y;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A sof in DRAIN starts the next frame while the previous one still publishes.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (acc_pix) state_d = last_pix ? ST_DRAIN : ST_RUN;
            end
            ST_RUN: begin
                if (last_pix) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (acc_pix)        state_d = last_pix ? ST_DRAIN : ST_RUN;
                else if (s2_last_q) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        acc_pix = pix_valid && (sof || (state_q == ST_RUN));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid_q   <= 1'b0;
            s1_skin_q    <= 1'b0;
            s1_acc_q     <= 1'b0;
            s1_sof_q     <= 1'b0;
            s1_last_q    <= 1'b0;
            s1_x_q       <= '0;
            s1_y_q       <= '0;
            mask_valid_q <= 1'b0;
            mask_bit_q   <= 1'b0;
            s2_last_q    <= 1'b0;
        end else begin
            s1_valid_q   <= pix_valid;
            s1_skin_q    <= pix_valid && skin_raw;
            s1_acc_q     <= acc_pix;
            s1_sof_q     <= pix_valid && sof;
            s1_last_q    <= last_pix;
            s1_x_q       <= cur_x;
            s1_y_q       <= cur_y;
            mask_valid_q <= s1_valid_q;
            mask_bit_q   <= s1_valid_q && s1_skin_q;
            s2_last_q    <= s1_last_q;
        end
    end

    // Bbox registers stay zero until the first skin pixel so an empty frame publishes zeros.
    always_comb begin
        acc_count_d = acc_count_q;
        acc_any_d   = acc_any_q;
        acc_xmin_d  = acc_xmin_q;
        acc_xmax_d  = acc_xmax_q;
        acc_ymin_d  = acc_ymin_q;
        acc_ymax_d  = acc_ymax_q;
        if (s1_acc_q) begin
            if (s1_sof_q) begin
                acc_count_d = {{(NW-1){1'b0}}, s1_skin_q};
                acc_any_d   = s1_skin_q;
                acc_xmin_d  = s1_skin_q ? s1_x_q : '0;
                acc_xmax_d  = s1_skin_q ? s1_x_q : '0;
                acc_ymin_d  = s1_skin_q ? s1_y_q : '0;
                acc_ymax_d  = s1_skin_q ? s1_y_q : '0;
            end else if (s1_skin_q) begin
                if (acc_count_q != '1) acc_count_d = acc_count_q + 1'b1;
                acc_any_d = 1'b1;
                if (!acc_any_q || (s1_x_q < acc_xmin_q)) acc_xmin_d = s1_x_q;
                if (!acc_any_q || (s1_x_q > acc_xmax_q)) acc_xmax_d = s1_x_q;
                if (!acc_any_q || (s1_y_q < acc_ymin_q)) acc_ymin_d = s1_y_q;
                if (!acc_any_q || (s1_y_q > acc_ymax_q)) acc_ymax_d = s1_y_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_count_q <= '0;
            acc_any_q   <= 1'b0;
            acc_xmin_q  <= '0;
            acc_xmax_q  <= '0;
            acc_ymin_q  <= '0;
            acc_ymax_q  <= '0;
        end else begin
            acc_count_q <= acc_count_d;
            acc_any_q   <= acc_any_d;
            acc_xmin_q  <= acc_xmin_d;
            acc_xmax_q  <= acc_xmax_d;
            acc_ymin_q  <= acc_ymin_d;
            acc_ymax_q  <= acc_ymax_d;
        end
    end

    // Snapshot bank: copies the finished frame while the accumulators may already restart.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            frame_done_q <= 1'b0;
            skin_count_q <= '0;
            bbox_valid_q <= 1'b0;
            bbox_xmin_q  <= '0;
            bbox_xmax_q  <= '0;
            bbox_ymin_q  <= '0;
            bbox_ymax_q  <= '0;
        end else begin
            frame_done_q <= s2_last_q;
            if (s2_last_q) begin
                skin_count_q <= acc_count_q;
                bbox_valid_q <= acc_any_q;
                bbox_xmin_q  <= acc_xmin_q;
                bbox_xmax_q  <= acc_xmax_q;
                bbox_ymin_q  <= acc_ymin_q;
                bbox_ymax_q  <= acc_ymax_q;
            end
        end
    end

    assign mask_valid = mask_valid_q;
    assign mask_bit   = mask_bit_q;
    assign frame_done = frame_done_q;
    assign skin_count = skin_count_q;
    assign bbox_valid = bbox_valid_q;
    assign bbox_xmin  = bbox_xmin_q;
    assign bbox_xmax  = bbox_xmax_q;
    assign bbox_ymin  = bbox_ymin_q;
    assign bbox_ymax  = bbox_ymax_q;

endmodule
